// File: rtl/uart_matrix_loader.sv
// UART 8N1 receiver that assembles 18 bytes into two 3x3 byte matrices (A then B).
// Optional inter-byte timeout abort is built when LOADER_TIMEOUT_EN is defined.
module uart_matrix_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 17360
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [71:0] a_flat,
    output logic [71:0] b_flat,
    output logic        load_done,
    output logic        frame_err,
    output logic        timeout,
    output logic [4:0]  byte_count
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || TIMEOUT_CLKS < 1) begin : g_bad_param
        $error("uart_matrix_loader: illegal CLKS_PER_BIT or TIMEOUT_CLKS");
    end

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [2:0]       r_state;
    logic [15:0]      r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    // Only 17 bytes are buffered; the 18th goes straight from the shifter into B.
    logic [16:0][7:0] r_shadow;
    logic [71:0]      r_a;
    logic [71:0]      r_b;
    logic [4:0]       r_count;
    logic             r_done;
    logic             r_ferr;

`ifdef LOADER_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic            r_timeout;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_idle_partial;
    logic            w_timeout_hit;

    assign w_idle_partial = (r_state == S_IDLE) && r_rx_sync && (r_count != 5'd0);
    assign w_timeout_hit  = w_idle_partial && (r_to_cnt == TO_LAST);
    assign timeout        = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_shadow  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_timeout <= 1'b0;
            r_to_cnt  <= '0;
`endif
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= S_START;
                        r_timer <= '0;
                    end
                end
                S_START: begin
                    if (r_timer == HALF_END) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_timer == BIT_END) begin
                        r_timer   <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_timer == BIT_END) begin
                        r_timer <= '0;
                        if (r_rx_sync) begin
                            r_state <= S_IDLE;
                            if (r_count == 5'd17) begin
                                r_a     <= r_shadow[8:0];
                                r_b     <= {r_shift, r_shadow[16:9]};
                                r_count <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_shadow[r_count] <= r_shift;
                                r_count           <= r_count + 5'd1;
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_sync) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef LOADER_TIMEOUT_EN
            // Timeout only fires in IDLE, so it never collides with the STOP-state byte commit.
            r_timeout <= 1'b0;
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
                r_count   <= '0;
                r_to_cnt  <= '0;
            end else if (w_idle_partial) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

    assign a_flat     = r_a;
    assign b_flat     = r_b;
    assign load_done  = r_done;
    assign frame_err  = r_ferr;
    assign byte_count = r_count;
endmodule

// File: tb/tb_uart_matrix_loader.sv
// Self-checking bench for uart_matrix_loader: directed table, corner sequences, random frames vs a set-level model.
module tb_uart_matrix_loader;
    localparam int CPB = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [71:0] a_flat, b_flat;
    logic        load_done, frame_err, timeout;
    logic [4:0]  byte_count;

    uart_matrix_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .a_flat(a_flat), .b_flat(b_flat),
        .load_done(load_done), .frame_err(frame_err), .timeout(timeout),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_done = 0, n_ferr = 0, n_to = 0, n_excl = 0, done_cyc = 0;
    always @(negedge clk) begin
        if (load_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (timeout) n_to <= n_to + 1;
        if (int'(load_done) + int'(frame_err) + int'(timeout) > 1) n_excl <= n_excl + 1;
    end

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Set-level model: bytes land in slots 0..17, the full set is published on the 18th.
    logic [7:0]  m_sh [18];
    int          m_cnt;
    logic [71:0] m_a, m_b;
    int          m_done, m_to;

    task automatic model_reset();
        foreach (m_sh[i]) m_sh[i] = 8'h00;
        m_cnt = 0; m_a = '0; m_b = '0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        m_sh[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 18) begin
            for (int i = 0; i < 9; i++) begin
                m_a[8*i +: 8] = m_sh[i];
                m_b[8*i +: 8] = m_sh[9+i];
            end
            m_cnt = 0;
            m_done++;
        end
    endtask

    // One 8N1 frame; stop bit lasts CPB-1 here so the next call's edge wait completes it exactly.
    task automatic send_byte(input logic [7:0] d, input logic stop_lvl, output int st);
        @(posedge clk); #1;
        st = cyc;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_lvl;
        repeat (CPB - 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rx = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_checked(input logic [7:0] d, input string tag);
        int st, d0;
        d0 = n_done;
        model_byte(d);
        send_byte(d, 1'b1, st);
        chk({tag, " count"}, 72'(byte_count), 72'(m_cnt));
        chk({tag, " a_flat"}, a_flat, m_a);
        chk({tag, " b_flat"}, b_flat, m_b);
        chk({tag, " done"}, 72'(n_done - d0), 72'(m_done > 0 && m_cnt == 0 ? 1 : 0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    initial begin
        vec_t tbl [18];
        int st, f0, d0, t0;
        logic [7:0] d;

        for (int i = 0; i < 18; i++) begin
            tbl[i].data     = (i < 9) ? 8'(i + 1) : 8'(18 - i);
            tbl[i].exp_cnt  = 5'((i + 1) % 18);
            tbl[i].exp_done = (i == 17);
        end
        model_reset();
        m_done = 0; m_to = 0;

        idle(3);
        rst = 1'b0;
        chk("reset a_flat", a_flat, 72'h0);
        chk("reset b_flat", b_flat, 72'h0);
        chk("reset count", 72'(byte_count), 72'h0);
        chk("reset load_done", 72'(load_done), 72'h0);
        chk("reset frame_err", 72'(frame_err), 72'h0);
        chk("reset timeout", 72'(timeout), 72'h0);
        idle(5);

        // Directed set: 1..9 then 9..1, sent back-to-back.
        for (int i = 0; i < 18; i++) begin
            d0 = n_done;
            model_byte(tbl[i].data);
            send_byte(tbl[i].data, 1'b1, st);
            chk("tbl count", 72'(byte_count), 72'(tbl[i].exp_cnt));
            chk("tbl done", 72'(n_done - d0), 72'(tbl[i].exp_done));
            if (!tbl[i].exp_done) chk("tbl a_flat hold", a_flat, 72'h0);
        end
        chk("set a_flat", a_flat, 72'h090807060504030201);
        chk("set b_flat", b_flat, 72'h010203040506070809);
        // 2 sync flops + half-bit start check + 8 data bits + stop bit, then the registered pulse.
        chk("load_done latency", 72'(done_cyc), 72'(st + 3 + CPB / 2 + 9 * CPB));
        idle(10);

        // Bad stop bit, line then held low: one error, no restart while low.
        f0 = n_ferr; d0 = n_done;
        send_byte(8'hA5, 1'b0, st);
        chk("ferr pulse", 72'(n_ferr - f0), 72'd1);
        chk("ferr count", 72'(byte_count), 72'd0);
        idle(100);
        chk("ferr held low", 72'(n_ferr - f0), 72'd1);
        rx = 1'b1;
        idle(40);
        chk("ferr after idle", 72'(n_ferr - f0), 72'd1);
        chk("ferr count after", 72'(byte_count), 72'd0);
        chk("ferr no done", 72'(n_done - d0), 72'd0);
        chk("ferr a_flat kept", a_flat, m_a);

        // Short low glitch on idle line.
        f0 = n_ferr; d0 = n_done;
        @(posedge clk); #1;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(60);
        chk("glitch count", 72'(byte_count), 72'd0);
        chk("glitch pulses", 72'((n_ferr - f0) + (n_done - d0)), 72'd0);

        // Partial set then reset: nothing of the partial set survives.
        for (int i = 0; i < 5; i++) send_checked(8'($urandom), "pre-rst");
        d0 = n_done; f0 = n_ferr;
        do_reset();
        chk("rst count", 72'(byte_count), 72'd0);
        chk("rst a_flat", a_flat, 72'h0);
        chk("rst b_flat", b_flat, 72'h0);
        idle(5);
        chk("rst pulses", 72'((n_done - d0) + (n_ferr - f0)), 72'd0);
        for (int i = 0; i < 18; i++) send_checked(8'($urandom), "post-rst");
        chk("post-rst done", 72'(n_done - d0), 72'd1);

        // Two full sets back-to-back.
        d0 = n_done;
        for (int i = 0; i < 36; i++) send_checked(8'($urandom), "two-sets");
        chk("two-sets done", 72'(n_done - d0), 72'd2);

        // Three bytes then a long idle.
        t0 = n_to;
        for (int i = 0; i < 3; i++) send_checked(8'($urandom), "to-pre");
        idle(TO + 100);
`ifdef LOADER_TIMEOUT_EN
        m_cnt = 0;
        m_to++;
        chk("timeout pulse", 72'(n_to - t0), 72'd1);
`else
        chk("no timeout pulse", 72'(n_to - t0), 72'd0);
`endif
        chk("timeout count", 72'(byte_count), 72'(m_cnt));
        chk("timeout a_flat", a_flat, m_a);

        // Random bytes, random gaps, occasional bad stop bit.
        for (int n = 0; n < 60; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                f0 = n_ferr;
                send_byte(d, 1'b0, st);
                rx = 1'b1;
                idle(20);
                chk("rnd ferr", 72'(n_ferr - f0), 72'd1);
                chk("rnd ferr count", 72'(byte_count), 72'(m_cnt));
            end else begin
                send_checked(d, "rnd");
            end
            idle($urandom_range(0, 30));
        end

        idle(20);
        chk("pulse exclusivity", 72'(n_excl), 72'd0);
        chk("total done", 72'(n_done), 72'(m_done));
        chk("total timeout", 72'(n_to), 72'(m_to));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
